fs_serial_nbit: RTL and testbench

Bit-serial N-bit subtractor with valid/ready handshakes at input and output. It is the inverse-direction companion to the parallel multi-bit full adder. It computes d = a − b − bi one bit per clock, LSB first, through a single full-subtractor cell. It serves as an area-lean arithmetic unit and as a sequential reference model for adder/subtractor benches.

---
 rtl/fs_pkg.sv | 16 +
 rtl/fs.sv | 14 +
 rtl/fs_serial_nbit.sv | 148 ++++++++++++++
 tb/tb_fs_serial_nbit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
// Latency: n/a (package). Backpressure: n/a.
package fs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fs_state_e;

    // Wide enough to hold SIZE itself, so SIZE=1 still gets a 1-bit counter.
    function automatic int fs_cnt_w(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/fs.sv
// One-bit full subtractor cell: diff = x - y - bin, bout = borrow out.
// Latency: combinational. Backpressure: none.
module fs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/fs_serial_nbit.sv
// Bit-serial d = a - b - bi, LSB first through one fs cell; FS_SERIAL_OVF_EN adds the ovf port.
// Latency: SIZE cycles from acceptance to out_valid; one op per SIZE+2 cycles minimum.
// Backpressure: DONE holds all outputs until out_ready; in_ready is high only in IDLE.
module fs_serial_nbit
    import fs_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bi,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] d,
    output logic            bo,
    output logic            busy
`ifdef FS_SERIAL_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int               CW       = fs_cnt_w(SIZE);
    localparam logic [CW-1:0]    CNT_LAST = CW'(SIZE - 1);

    fs_state_e       state_q, state_d;
    logic [SIZE-1:0] a_sh_q, a_sh_d;
    logic [SIZE-1:0] b_sh_q, b_sh_d;
    logic [SIZE-1:0] d_sh_q, d_sh_d;
    logic            brw_q, brw_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            cell_diff;
    logic            cell_bout;
    logic [SIZE-1:0] d_shift;

    fs u_fs (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (brw_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Each new difference bit enters at the MSB, so after SIZE steps bit 0 sits at d[0].
    generate
        if (SIZE == 1) begin : g_one
            assign d_shift = cell_diff;
        end else begin : g_multi
            assign d_shift = {cell_diff, d_sh_q[SIZE-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bi;
                    d_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = d_shift;
                brw_d  = cell_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign d         = d_sh_q;
    assign bo        = brw_q;

`ifdef FS_SERIAL_OVF_EN
    // The shift registers lose the operand MSBs, so keep them from the accept cycle.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (state_q == IDLE && in_valid) begin
            a_msb_d = a[SIZE-1];
            b_msb_d = b[SIZE-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign ovf = out_valid && (a_msb_q != b_msb_q) && (d_sh_q[SIZE-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_fs_serial_nbit.sv
// Self-checking bench for fs_serial_nbit: directed table, backpressure, mid-RUN reset, random ops.
module tb_fs_serial_nbit;

    localparam int SIZE = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bi;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] d;
    logic            bo;
    logic            busy;
`ifdef FS_SERIAL_OVF_EN
    logic            ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fs_serial_nbit #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bo        (bo),
        .busy      (busy)
`ifdef FS_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic            bi;
        logic [SIZE-1:0] d;
        logic            bo;
        logic            ovf;
        int              dly;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference from plain integer arithmetic: wrap the difference, borrow = unsigned a < b+bi.
    function automatic void model(input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                                  input logic biv, output logic [SIZE-1:0] dv,
                                  output logic bov, output logic ovv);
        int ia;
        int ib;
        int diff;
        ia   = int'(av);
        ib   = int'(bv);
        diff = ia - ib - int'(biv);
        dv   = SIZE'(diff + (1 << SIZE));
        bov  = (diff < 0);
        ovv  = (av[SIZE-1] != bv[SIZE-1]) && (dv[SIZE-1] != av[SIZE-1]);
    endfunction

    // One full transaction; dly cycles of out_ready low, optional ignored in_valid pokes meanwhile.
    task automatic do_op(input string tag, input logic [SIZE-1:0] av, input logic [SIZE-1:0] bv,
                         input logic biv, input logic [SIZE-1:0] ed, input logic ebo,
                         input logic eovf, input int dly, input bit poke);
        int  cyc;
        bit  seen;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        a         = av;
        b         = bv;
        bi        = biv;
        in_valid  = 1'b1;
        out_ready = (dly == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen     = 1'b0;
        cyc      = 0;
        for (int i = 1; i <= SIZE + 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
        end
        if (!seen) begin
            chk({tag, "_out_valid_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_latency"}, cyc, SIZE);
        chk({tag, "_d"}, d, ed);
        chk({tag, "_bo"}, bo, ebo);
        chk({tag, "_in_ready_done"}, in_ready, 0);
        chk({tag, "_busy_done"}, busy, 1);
`ifdef FS_SERIAL_OVF_EN
        chk({tag, "_ovf"}, ovf, eovf);
`else
        if (eovf === 1'bx) chk({tag, "_ovf_x"}, eovf, 0);
`endif
        for (int i = 0; i < dly; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a        = ~av;
                b        = ~bv;
            end
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_d"}, d, ed);
            chk({tag, "_hold_bo"}, bo, ebo);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_out_valid_after"}, out_valid, 0);
        chk({tag, "_in_ready_after"}, in_ready, 1);
        if (poke) begin
            @(posedge clk);
            #1;
            chk({tag, "_poke_not_accepted"}, busy, 0);
        end
    endtask

    initial begin
        vec_t            tbl[6];
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;
        logic            rbi;
        logic [SIZE-1:0] md;
        logic            mbo;
        logic            movf;

        tbl[0] = '{a: 8'h35, b: 8'h24, bi: 1'b0, d: 8'h11, bo: 1'b0, ovf: 1'b0, dly: 0};
        tbl[1] = '{a: 8'h24, b: 8'h35, bi: 1'b0, d: 8'hEF, bo: 1'b1, ovf: 1'b0, dly: 2};
        tbl[2] = '{a: 8'h00, b: 8'h00, bi: 1'b1, d: 8'hFF, bo: 1'b1, ovf: 1'b0, dly: 0};
        tbl[3] = '{a: 8'hFF, b: 8'hFF, bi: 1'b0, d: 8'h00, bo: 1'b0, ovf: 1'b0, dly: 1};
        tbl[4] = '{a: 8'h80, b: 8'h01, bi: 1'b0, d: 8'h7F, bo: 1'b0, ovf: 1'b1, dly: 0};
        tbl[5] = '{a: 8'h05, b: 8'h03, bi: 1'b0, d: 8'h02, bo: 1'b0, ovf: 1'b0, dly: 3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bi        = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_d", d, 0);
        chk("rst_bo", bo, 0);
`ifdef FS_SERIAL_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bi,
                  tbl[i].d, tbl[i].bo, tbl[i].ovf, tbl[i].dly, 1'b0);
        end

        do_op("backpressure", 8'h35, 8'h24, 1'b0, 8'h11, 1'b0, 1'b0, 5, 1'b1);

        // Reset three cycles into RUN must discard everything at once.
        @(negedge clk);
        a        = 8'hA5;
        b        = 8'h5A;
        bi       = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", out_valid, 0);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_d", d, 0);
        chk("midrun_rst_bo", bo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra  = SIZE'($urandom);
            rb  = SIZE'($urandom);
            rbi = 1'($urandom);
            model(ra, rb, rbi, md, mbo, movf);
            do_op($sformatf("rnd%0d", i), ra, rb, rbi, md, mbo, movf,
                  int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
